// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download sequencer.
// Holds the FSM state enum and the byte counter width.
package rom_dl_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} rom_dl_state_t;
    localparam int BYTE_COUNT_W = 17;
endpackage

// File: rtl/rom_dl_bank_decode.sv
// Combinational ioctl address decoder: one-hot bank select,
// in-bank offset and range check (any bit above the bank index).
// Ports: addr_i (25b) -> bank_o (BANKS), offset_o (BANK_SHIFT), in_range_o.
module rom_dl_bank_decode #(
    parameter int BANKS      = 4,
    parameter int BANK_SHIFT = 11
) (
    input  logic [24:0]           addr_i,
    output logic [BANKS-1:0]      bank_o,
    output logic [BANK_SHIFT-1:0] offset_o,
    output logic                  in_range_o
);
    import rom_dl_pkg::*;

    localparam int IDX_W = $clog2(BANKS);
    localparam int TOP   = BANK_SHIFT + IDX_W;

    logic [IDX_W-1:0] idx;
    logic [24:0]      upper;

    assign idx        = addr_i[BANK_SHIFT +: IDX_W];
    assign upper      = addr_i >> TOP;
    assign in_range_o = (upper == '0);
    assign offset_o   = addr_i[BANK_SHIFT-1:0];

    always_comb begin
        bank_o = '0;
        for (int b = 0; b < BANKS; b++) begin
            bank_o[b] = in_range_o && (idx == IDX_W'(b));
        end
    end
endmodule

// File: rtl/rom_dl_sequencer.sv
// Sequences the HPS ioctl ROM download into one-hot ROM bank writes and
// holds the core in reset around it. Optional ROM_DL_CHECKSUM_EN adds a
// mod-256 byte sum (port checksum, parameter EXPECTED_SUM).
// Ports: clk_sys, Reset_I (async, active-low), ioctl_* download inputs;
// wr_en/wr_bank/wr_addr/wr_data ROM writes; core_reset_n, busy, done,
// err, byte_count status. All outputs are registered.
module rom_dl_sequencer
    import rom_dl_pkg::*;
#(
    parameter int BANKS          = 4,
    parameter int BANK_SHIFT     = 11,
    parameter int EXPECTED_BYTES = 8192,
    parameter int HOLD_CYCLES    = 1024
`ifdef ROM_DL_CHECKSUM_EN
    ,
    parameter logic [7:0] EXPECTED_SUM = 8'h00
`endif
) (
    input  logic                    clk_sys,
    input  logic                    Reset_I,
    input  logic                    ioctl_download,
    input  logic                    ioctl_wr,
    input  logic [24:0]             ioctl_addr,
    input  logic [7:0]              ioctl_dout,
    output logic                    wr_en,
    output logic [BANKS-1:0]        wr_bank,
    output logic [BANK_SHIFT-1:0]   wr_addr,
    output logic [7:0]              wr_data,
    output logic                    core_reset_n,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [BYTE_COUNT_W-1:0] byte_count
`ifdef ROM_DL_CHECKSUM_EN
    ,
    output logic [7:0]              checksum
`endif
);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    rom_dl_state_t             state_q;
    logic [HOLD_W-1:0]         hold_q;
    logic                      dl_q;
    logic                      range_q, range_d;
    logic [BYTE_COUNT_W-1:0]   count_q, count_d;
    logic                      wr_en_q;
    logic [BANKS-1:0]          wr_bank_q;
    logic [BANK_SHIFT-1:0]     wr_addr_q;
    logic [7:0]                wr_data_q;
    logic                      rstn_q, busy_q, done_q, err_q;

    logic [BANKS-1:0]          dec_bank;
    logic [BANK_SHIFT-1:0]     dec_off;
    logic                      dec_ok;
    logic                      in_load, accept, dl_rise, dl_fall;
    logic                      sum_ok, image_ok;

    rom_dl_bank_decode #(
        .BANKS     (BANKS),
        .BANK_SHIFT(BANK_SHIFT)
    ) u_dec (
        .addr_i    (ioctl_addr),
        .bank_o    (dec_bank),
        .offset_o  (dec_off),
        .in_range_o(dec_ok)
    );

    assign in_load = (state_q == LOAD);
    assign accept  = in_load && ioctl_wr && dec_ok;
    assign dl_rise = ioctl_download && !dl_q;
    assign dl_fall = !ioctl_download && dl_q;

`ifdef ROM_DL_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    assign sum_d    = accept ? sum_q + ioctl_dout : sum_q;
    assign sum_ok   = (sum_d == EXPECTED_SUM);
    assign checksum = sum_q;
`else
    assign sum_ok = 1'b1;
`endif

    // A strobe in the same cycle as the falling edge is folded into the
    // *_d values so the end-of-download check already includes it.
    always_comb begin
        range_d = range_q | (in_load && ioctl_wr && !dec_ok);
        count_d = count_q;
        if (accept && count_q != '1) begin
            count_d = count_q + 1'b1;
        end
    end

    assign image_ok = (count_d == BYTE_COUNT_W'(EXPECTED_BYTES))
                   && !range_d && sum_ok;

    always_ff @(posedge clk_sys or negedge Reset_I) begin
        if (!Reset_I) begin
            state_q   <= HOLD;
            hold_q    <= HOLD_LOAD;
            dl_q      <= 1'b0;
            range_q   <= 1'b0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_bank_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rstn_q    <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef ROM_DL_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            dl_q      <= ioctl_download;
            wr_en_q   <= accept;
            wr_bank_q <= accept ? dec_bank : '0;
            if (accept) begin
                wr_addr_q <= dec_off;
                wr_data_q <= ioctl_dout;
            end
            if (!in_load && dl_rise) begin
                state_q <= LOAD;
                count_q <= '0;
                range_q <= 1'b0;
                err_q   <= 1'b0;
                done_q  <= 1'b0;
                rstn_q  <= 1'b0;
                busy_q  <= 1'b1;
`ifdef ROM_DL_CHECKSUM_EN
                sum_q   <= '0;
`endif
            end else begin
                unique case (state_q)
                    HOLD: begin
                        if (hold_q == '0) begin
                            state_q <= RUN;
                            rstn_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            hold_q <= hold_q - 1'b1;
                        end
                    end
                    LOAD: begin
                        count_q <= count_d;
                        range_q <= range_d;
`ifdef ROM_DL_CHECKSUM_EN
                        sum_q   <= sum_d;
`endif
                        if (dl_fall) begin
                            if (image_ok) begin
                                state_q <= HOLD;
                                hold_q  <= HOLD_LOAD;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                                err_q   <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    IDLE: begin
                    end
                    RUN: begin
                    end
                endcase
            end
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_bank      = wr_bank_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign core_reset_n = rstn_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign byte_count   = count_q;
endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Testbench for rom_dl_sequencer: random-gap downloads checked by a
// write scoreboard plus an address-arithmetic model of the image rules.
module tb_rom_dl_sequencer;
    localparam int BANKS = 4;
    localparam int BSZ   = 2048;
    localparam int EXPB  = 8192;
    localparam int HOLD  = 1024;

    logic        clk_sys = 0;
    logic        Reset_I = 0;
    logic        ioctl_download = 0;
    logic        ioctl_wr = 0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        wr_en;
    logic [3:0]  wr_bank;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        core_reset_n, busy, done, err;
    logic [16:0] byte_count;
`ifdef ROM_DL_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    rom_dl_sequencer dut (
        .clk_sys(clk_sys), .Reset_I(Reset_I),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .wr_data(wr_data), .core_reset_n(core_reset_n), .busy(busy),
        .done(done), .err(err), .byte_count(byte_count)
`ifdef ROM_DL_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int failures = 0;
    logic [22:0] exp_q[$];
    bit   m_in_load = 0;
    int   m_count = 0;
    bit   m_range = 0;
    logic [7:0] m_sum = 0;

    task automatic chk(input string nm, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, expv);
        end
    endtask

    // Scoreboard monitor: every wr_en must match the oldest expected write.
    always @(negedge clk_sys) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wr_en", {wr_bank, wr_addr, wr_data}, 0);
            end else begin
                chk("write", {wr_bank, wr_addr, wr_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk_reset(input string tg);
        chk({tg, "_wr_en"}, wr_en, 0);
        chk({tg, "_wr_bank"}, wr_bank, 0);
        chk({tg, "_wr_addr"}, wr_addr, 0);
        chk({tg, "_wr_data"}, wr_data, 0);
        chk({tg, "_core_reset_n"}, core_reset_n, 0);
        chk({tg, "_busy"}, busy, 1);
        chk({tg, "_done"}, done, 0);
        chk({tg, "_err"}, err, 0);
        chk({tg, "_byte_count"}, byte_count, 0);
    endtask

    task automatic wait_release(input string nm);
        int n = 0;
        while (core_reset_n !== 1'b1 && n < HOLD + 50) begin
            @(posedge clk_sys); #1;
            n++;
        end
        chk(nm, n, HOLD);
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d,
                          input bit last);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr = 1;
        if (last) ioctl_download = 0;
        if (m_in_load) begin
            if (a < BANKS * BSZ) begin
                logic [3:0] oh;
                oh = 4'd1 << (a / BSZ);
                exp_q.push_back({oh, 11'(a % BSZ), d});
                if (m_count < 131071) m_count++;
                m_sum = m_sum + d;
            end else begin
                m_range = 1;
            end
        end
        @(posedge clk_sys); #1;
        ioctl_wr = 0;
        if (!last && $urandom_range(0, 7) == 0) begin
            @(posedge clk_sys); #1;
        end
    endtask

    // mode 0: data = addr[7:0]; mode 1: random data.
    task automatic download(input int n, input int mode, input int extra,
                            input int bump, input bit wait_rel);
        bit ok;
        ioctl_download = 1;
        @(posedge clk_sys); #1;
        m_in_load = 1; m_count = 0; m_range = 0; m_sum = 0;
        chk("load_byte_count", byte_count, 0);
        chk("load_done", done, 0);
        chk("load_err", err, 0);
        chk("load_core_reset_n", core_reset_n, 0);
        chk("load_busy", busy, 1);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            logic [24:0] a;
            if (extra >= 0 && i == n / 2) strobe(25'(extra), 8'hA5, 0);
            a = 25'(i);
            d = (mode == 0) ? a[7:0] : 8'($urandom);
            if (i == bump) d = d + 8'd1;
            strobe(a, d, i == n - 1);
        end
        m_in_load = 0;
        ok = (m_count == EXPB) && !m_range;
`ifdef ROM_DL_CHECKSUM_EN
        ok = ok && (m_sum == 8'h00);
        chk("end_checksum", checksum, m_sum);
`endif
        chk("end_byte_count", byte_count, m_count);
        chk("end_done", done, ok);
        chk("end_err", err, !ok);
        chk("end_busy", busy, ok);
        chk("end_core_reset_n", core_reset_n, 0);
        @(negedge clk_sys); #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        if (wait_rel) wait_release("dl_release_cycles");
    endtask

    initial begin
        repeat (3) @(posedge clk_sys);
        #1;
        chk_reset("rst");
        @(negedge clk_sys);
        Reset_I = 1;
        wait_release("rst_release_cycles");
        chk("run_done", done, 0);
        chk("run_err", err, 0);
        chk("run_busy", busy, 0);

        download(EXPB, 0, -1, -1, 1);

        download(EXPB - 1, 1, -1, -1, 0);
        repeat (1100) @(posedge clk_sys);
        #1;
        chk("short_stuck_core_reset_n", core_reset_n, 0);
        chk("short_idle_busy", busy, 0);

        download(EXPB, 0, -1, -1, 0);
        repeat (100) @(posedge clk_sys);
        #1;
        chk("hold_core_reset_n", core_reset_n, 0);
        chk("hold_busy", busy, 1);

        download(EXPB, 0, 32'h2000, -1, 0);

`ifdef ROM_DL_CHECKSUM_EN
        download(EXPB, 0, -1, 5, 0);
        chk("bump_checksum", checksum, 8'h01);
`endif

        download(EXPB, 0, -1, -1, 1);

        ioctl_download = 1;
        @(posedge clk_sys); #1;
        m_in_load = 1; m_count = 0; m_range = 0;
        for (int i = 0; i < 40; i++) begin
            logic [24:0] a;
            a = ($urandom_range(0, 3) == 0) ? 25'($urandom) | 25'h2000
                                            : 25'($urandom_range(0, EXPB - 1));
            strobe(a, 8'($urandom), 0);
        end
        ioctl_addr = 25'h10;
        ioctl_dout = 8'h5A;
        ioctl_wr = 1;
        @(posedge clk_sys);
        #2 Reset_I = 0;
        #1;
        chk_reset("midload_rst");
        exp_q.delete();
        m_in_load = 0;
        ioctl_wr = 0;
        ioctl_download = 0;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        Reset_I = 1;
        wait_release("midload_release_cycles");
        chk("final_done", done, 0);
        chk("final_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
